// File: rtl/mem_port2_arbiter_pkg.sv
// Shared types for the second memory port arbiter: owner state and read-tag encoding.
// The display controller reuses both enums, so keep the encodings stable.
package mem_port2_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VGA      = 2'd1,
    ENG      = 2'd2,
    ENG_LOCK = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_VGA  = 2'd1,
    RD_ENG  = 2'd2
  } rd_tag_e;

endpackage

// File: rtl/mem_port2_arbiter_if.sv
// Bundle of VGA requester, engine requester and memory port-2 signals.
// slave = arbiter view, master = requesters plus memory block.
interface mem_port2_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  vga_req;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic                  vga_gnt;
  logic                  vga_rvalid;
  logic [DATA_WIDTH-1:0] vga_rdata;

  logic                  eng_req;
  logic                  eng_we;
  logic                  eng_lock;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_wdata;
  logic                  eng_gnt;
  logic                  eng_rvalid;
  logic [DATA_WIDTH-1:0] eng_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    input  eng_req, eng_we, eng_lock, eng_addr, eng_wdata,
    output eng_gnt, eng_rvalid, eng_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    output eng_req, eng_we, eng_lock, eng_addr, eng_wdata,
    input  eng_gnt, eng_rvalid, eng_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port2_arbiter.sv
// Arbitrates memory port 2 between the VGA reader and the game engine (with RMW lock),
// bounding engine starvation (wait_cnt) and VGA lockout (lock_cnt); tags read returns.
module mem_port2_arbiter
  import mem_port2_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 4,
  parameter int MAX_LOCK   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port2_arbiter_if.slave bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_SAT = LW'(MAX_LOCK);

  arb_state_e            state, state_nxt;
  rd_tag_e               rd_tag, rd_tag_nxt;
  logic [WW-1:0]         wait_cnt, wait_nxt;
  logic [LW-1:0]         lock_cnt, lock_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, mem_addr;
  logic [DATA_WIDTH-1:0] vga_rdata_q, eng_rdata_q, vga_rdata, eng_rdata;
  logic                  vga_win, eng_win, locked, vga_rvalid, eng_rvalid;

  assign locked = (state == ENG_LOCK);

  // Grant decision; gated by reset_n so nothing is issued while reset is held.
  always_comb begin
    vga_win = 1'b0;
    eng_win = 1'b0;
    if (reset_n) begin
      if (locked && bus.eng_req) begin
        if (lock_cnt == LOCK_SAT && bus.vga_req) vga_win = 1'b1;
        else                                     eng_win = 1'b1;
      end else if (bus.eng_req && wait_cnt == WAIT_SAT) begin
        eng_win = 1'b1;
      end else if (bus.vga_req) begin
        vga_win = 1'b1;
      end else if (bus.eng_req) begin
        eng_win = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = IDLE;
    lock_nxt   = '0;
    wait_nxt   = '0;
    rd_tag_nxt = RD_NONE;

    if (eng_win) begin
      state_nxt = bus.eng_lock ? ENG_LOCK : ENG;
      // Counts grants of a locked sequence while VGA is kept waiting, including the entry grant.
      if (bus.eng_lock && bus.vga_req)
        lock_nxt = (lock_cnt == LOCK_SAT) ? lock_cnt : lock_cnt + 1'b1;
    end else if (locked && bus.eng_req) begin
      // One-cycle VGA break inside a lock; the lock survives if the engine still asks for it.
      state_nxt = bus.eng_lock ? ENG_LOCK : VGA;
    end else if (locked) begin
      state_nxt = IDLE;
    end else if (vga_win) begin
      state_nxt = VGA;
    end

    if (bus.eng_req && !eng_win)
      wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 1'b1;

    if (vga_win)                     rd_tag_nxt = RD_VGA;
    else if (eng_win && !bus.eng_we) rd_tag_nxt = RD_ENG;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lock_cnt    <= '0;
      rd_tag      <= RD_NONE;
      addr_q      <= '0;
      vga_rdata_q <= '0;
      eng_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      lock_cnt    <= lock_nxt;
      rd_tag      <= rd_tag_nxt;
      addr_q      <= mem_addr;
      vga_rdata_q <= vga_rdata;
      eng_rdata_q <= eng_rdata;
    end
  end

  // Address holds its last issued value on idle cycles.
  assign mem_addr   = vga_win ? bus.vga_addr : (eng_win ? bus.eng_addr : addr_q);
  assign vga_rvalid = (rd_tag == RD_VGA);
  assign eng_rvalid = (rd_tag == RD_ENG);
  assign vga_rdata  = vga_rvalid ? bus.mem_rdata : vga_rdata_q;
  assign eng_rdata  = eng_rvalid ? bus.mem_rdata : eng_rdata_q;

  assign bus.vga_gnt    = vga_win;
  assign bus.eng_gnt    = eng_win;
  assign bus.mem_we     = eng_win & bus.eng_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = bus.eng_wdata;
  assign bus.vga_rvalid = vga_rvalid;
  assign bus.eng_rvalid = eng_rvalid;
  assign bus.vga_rdata  = vga_rdata;
  assign bus.eng_rdata  = eng_rdata;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Randomized + directed bench for mem_port2_arbiter against a rule-level reference model
// and a behavioural synchronous memory on port 2.
module tb_mem_port2_arbiter;
  import mem_port2_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MW = 4;
  localparam int ML = 8;

  logic gclk_unused;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port2_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  mem_port2_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW), .MAX_LOCK(ML)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Memory block: synchronous read, write commits at the edge ending the grant cycle.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port by the arbitration rules, plus a shadow memory.
  logic [DW-1:0] sm [0:65535];
  int            m_wait, m_lockrun;
  bit            m_locked;
  logic [AW-1:0] m_last;
  bit            p_vga, p_eng;
  logic [DW-1:0] p_data, e_vrd, e_erd;

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 16'h0100) ? 16'hBEEF : DW'(a ^ 16'h5A5A);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_lockrun = 0; m_locked = 0; m_last = '0;
    p_vga = 0; p_eng = 0; p_data = '0; e_vrd = '0; e_erd = '0;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge, advance the model.
  // w: 0 = no grant, 1 = VGA, 2 = engine.
  task automatic cycle(input bit vr, input logic [AW-1:0] va, input bit er, input bit ew,
                       input bit el, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       output int w);
    logic [AW-1:0] xa;
    @(posedge clk); #1;
    bus.vga_req = vr; bus.vga_addr = va;
    bus.eng_req = er; bus.eng_we = ew; bus.eng_lock = el; bus.eng_addr = ea; bus.eng_wdata = ed;
    @(negedge clk);

    if (m_locked && er)            w = (m_lockrun >= ML && vr) ? 1 : 2;
    else if (er && m_wait >= MW)   w = 2;
    else if (vr)                   w = 1;
    else if (er)                   w = 2;
    else                           w = 0;

    if (p_vga) e_vrd = p_data;
    if (p_eng) e_erd = p_data;
    chk("vga_rvalid", bus.vga_rvalid, p_vga);
    chk("eng_rvalid", bus.eng_rvalid, p_eng);
    chk("vga_rdata", bus.vga_rdata, e_vrd);
    chk("eng_rdata", bus.eng_rdata, e_erd);
    chk("vga_gnt", bus.vga_gnt, w == 1);
    chk("eng_gnt", bus.eng_gnt, w == 2);
    chk("mem_we", bus.mem_we, (w == 2) && ew);
    xa = (w == 1) ? va : ((w == 2) ? ea : m_last);
    chk("mem_addr", bus.mem_addr, xa);
    if (w == 2 && ew) chk("mem_wdata", bus.mem_wdata, ed);

    p_vga  = (w == 1);
    p_eng  = (w == 2) && !ew;
    p_data = sm[xa];
    if (w == 2 && ew) sm[ea] = ed;
    m_last = xa;

    m_wait = (er && w != 2) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
    if (w == 2) begin
      m_locked  = el;
      m_lockrun = (el && vr) ? ((m_lockrun < ML) ? m_lockrun + 1 : ML) : 0;
    end else if (m_locked && er) begin
      m_locked  = el;
      m_lockrun = 0;
    end else begin
      m_locked  = 0;
      m_lockrun = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.vga_req = 1; bus.eng_req = 1; bus.eng_we = 1; bus.eng_lock = 1;
    bus.vga_addr = 16'h0055; bus.eng_addr = 16'h0066; bus.eng_wdata = 16'h7777;
    @(negedge clk);
    chk("rst_vga_gnt", bus.vga_gnt, 0);
    chk("rst_eng_gnt", bus.eng_gnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_vga_rvalid", bus.vga_rvalid, 0);
    chk("rst_eng_rvalid", bus.eng_rvalid, 0);
    chk("rst_vga_rdata", bus.vga_rdata, 0);
    chk("rst_eng_rdata", bus.eng_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_state", dut.state, IDLE);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.vga_req = 0; bus.eng_req = 0; bus.eng_we = 0; bus.eng_lock = 0;
    model_reset();
  endtask

  initial begin
    int w, xw;
    bit vr, er, ew, el;
    logic [AW-1:0] va, ea;
    logic [DW-1:0] ed;

    for (int i = 0; i < 65536; i++) begin
      mem[i] <= init_word(i);
      sm[i]   = init_word(i);
    end
    bus.vga_req = 0; bus.vga_addr = '0;
    bus.eng_req = 0; bus.eng_we = 0; bus.eng_lock = 0; bus.eng_addr = '0; bus.eng_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset with both requesting, then first grant goes to VGA.
    do_reset();
    cycle(1, 16'h0100, 1, 0, 0, 16'h0300, 16'h0, w);
    chk("first_gnt_vga", w, 1);
    // VGA read of 0x0100 returns 0xBEEF one cycle later.
    cycle(1, 16'h0100, 0, 0, 0, 16'h0300, 16'h0, w);
    chk("vga_read_gnt", w, 1);
    cycle(0, 16'h0100, 0, 0, 0, 16'h0300, 16'h0, w);
    chk("vga_beef", bus.vga_rdata, 16'hBEEF);
    chk("vga_beef_eng_rvalid", bus.eng_rvalid, 0);

    // Constant requests: four VGA grants, one engine grant, repeating.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(1, 16'h0010, 1, 0, 0, 16'h0020, 16'h0, w);
      xw = ((i % 5) == 4) ? 2 : 1;
      chk("starve_pattern", w, xw);
    end

    // Engine write then read-back of the same address.
    do_reset();
    cycle(0, 16'h0, 1, 1, 0, 16'h0200, 16'h1234, w);
    chk("wr_gnt", w, 2);
    cycle(0, 16'h0, 1, 0, 0, 16'h0200, 16'h0, w);
    cycle(0, 16'h0, 0, 0, 0, 16'h0200, 16'h0, w);
    chk("raw_rdata", bus.eng_rdata, 16'h1234);
    chk("raw_rvalid", bus.eng_rvalid, 1);

    // Locked RMW against continuous VGA: 4 VGA, then 8 engine / 1 VGA repeating.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      cycle(1, 16'h0040, 1, 0, 1, 16'h0080, 16'h0, w);
      xw = (i < 4) ? 1 : ((((i - 4) % 9) == 8) ? 1 : 2);
      chk("lock_pattern", w, xw);
    end

    // Reset pulse the cycle after a granted read drops the return.
    do_reset();
    cycle(1, 16'h0100, 0, 0, 0, 16'h0, 16'h0, w);
    chk("pre_rst_gnt", w, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, w);
      chk("post_rst_vga_rvalid", bus.vga_rvalid, 0);
    end

    // Randomized traffic; requesters hold their request until granted.
    vr = 0; er = 0; ew = 0; el = 0; va = '0; ea = '0; ed = '0; w = 0;
    for (int i = 0; i < 3000; i++) begin
      int lock_pct;
      lock_pct = (((i / 250) % 2) != 0) ? 90 : 15;
      if (!vr || w == 1) begin
        vr = ($urandom_range(0, 99) < 70);
        va = AW'($urandom);
      end
      if (!er || w == 2) begin
        er = ($urandom_range(0, 99) < 60);
        ew = ($urandom_range(0, 1) == 1);
        el = er && ($urandom_range(0, 99) < lock_pct);
        ea = AW'($urandom_range(0, 31));
        ed = DW'($urandom);
      end
      cycle(vr, va, er, ew, el, ea, ed, w);
      if (i == 1500) begin
        do_reset();
        vr = 0; er = 0; w = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
